// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pkg
//  Description : Shared pipeline defines for the EX->MEM register: reset
//                polarity, write-enable levels, bus widths, stall levels and
//                stall-vector bit positions, plus the per-edge action decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  // Reset is active-low throughout the pipeline
  localparam logic RstEnable    = 1'b0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int   RegBus       = 32;
  localparam int   RegAddrBus   = 5;
  localparam int   DoubleRegBus = 64;
  localparam int   CntBus       = 2;
  localparam int   StallBus     = 6;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall-vector bit positions
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // What the register does on a given edge, in priority order
  localparam int ACT_W = 2;
  typedef enum logic [ACT_W-1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_PASS   = 2'd2,
    ACT_HOLD   = 2'd3
  } ex_mem_act_e;

  // Flush beats everything; EX held with MEM running drops a bubble into MEM
  function automatic ex_mem_act_e ex_mem_action(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
    if (flush)                                      return ACT_FLUSH;
    else if (stall_ex == Stop && stall_mem == NoStop) return ACT_BUBBLE;
    else if (stall_ex == NoStop)                    return ACT_PASS;
    else                                            return ACT_HOLD;
  endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem
//  Description : EX->MEM pipeline register with flush, stall-bubble insertion
//                and hold. Returns the multiply-accumulate temp and its cycle
//                counter to EX so a two-cycle MADD/MSUB survives a stall.
//                Optional macro EX_MEM_PERF_EN adds a 32-bit bubble counter
//                output (bubble_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = RegBus,
  parameter int ADDR_W  = RegAddrBus,
  parameter int CNT_W   = CntBus,
  parameter int STALL_W = StallBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]         bubble_cnt
`endif
);

  ex_mem_act_e w_act;

  // Only the EX and MEM stall bits matter to this stage
  logic w_unused_stall;
  assign w_unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  logic [ADDR_W-1:0]   wd_q,    wd_d;
  logic                wreg_q,  wreg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q,    hi_d;
  logic [DATA_W-1:0]   lo_q,    lo_d;
  logic                whilo_q, whilo_d;
  logic                valid_q, valid_d;
  logic [2*DATA_W-1:0] hilo_q,  hilo_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  assign w_act = ex_mem_action(flush, stall[STALL_EX], stall[STALL_MEM]);

  // Next-state selection for every slot field according to the edge action
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    valid_d = valid_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    unique case (w_act)
      ACT_FLUSH: begin
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WriteDisable;
        valid_d = 1'b0;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        // Bubble into MEM, but keep EX's partial MADD/MSUB result alive
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = WriteDisable;
        valid_d = 1'b0;
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end
      ACT_PASS: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        whilo_d = ex_whilo;
        valid_d = 1'b1;
        hilo_d  = '0;
        cnt_d   = '0;
      end
      default: begin
        // ACT_HOLD: everything keeps its value (defaults above)
      end
    endcase
  end

  // Slot register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q    <= '0;
      wreg_q  <= WriteDisable;
      wdata_q <= ZeroWord[DATA_W-1:0];
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WriteDisable;
      valid_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      valid_q <= valid_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign mem_valid = valid_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_cnt_q;

  // Count bubble-insertion edges; flush neither counts nor clears, wraps freely
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      bubble_cnt_q <= '0;
    end else if (w_act == ACT_BUBBLE) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule : ex_mem
`default_nettype wire
